// File: rtl/clk_enable_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : clk_enable_gen
// Description : Multi-channel fractional clock-enable generator. Each channel
//               runs a phase accumulator and emits one-cycle ce pulses on
//               carry-out. It has a per-channel lock flag after a programmable
//               number of pulses. Increments are reprogrammed through a
//               two-state valid/ready configuration port.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_enable_gen #(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned ACC_W       = 16,
    parameter logic [31:0] INIT_INC    = 32'h0000_4000,
    parameter int unsigned LOCK_PULSES = 4
) (
    input  logic                clkin,
    input  logic                reset_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [2:0]          cfg_ch,
    input  logic [ACC_W-1:0]    cfg_inc,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] ce_out,
    output logic [CHANNELS-1:0] lock
);

    localparam logic [0:0]       c_st_idle     = 1'b0;
    localparam logic [0:0]       c_st_apply    = 1'b1;
    localparam logic [ACC_W-1:0] c_init_inc    = INIT_INC[ACC_W-1:0];
    localparam logic [7:0]       c_lock_pulses = 8'(LOCK_PULSES);
    localparam logic [3:0]       c_channels    = 4'(CHANNELS);

    logic [0:0]       r_state;
    logic [2:0]       r_cfg_ch;
    logic [ACC_W-1:0] r_cfg_inc;
    logic             w_apply;
    logic             w_bad_ch;

    // Configuration FSM: accept a request in IDLE, spend exactly one cycle in
    // APPLY, which caps throughput at one request every two cycles.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_st_idle;
            r_cfg_ch  <= '0;
            r_cfg_inc <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (cfg_valid) begin
                        r_state   <= c_st_apply;
                        r_cfg_ch  <= cfg_ch;
                        r_cfg_inc <= cfg_inc;
                    end
                end
                c_st_apply: r_state <= c_st_idle;
                default:    r_state <= c_st_idle;
            endcase
        end
    end

    assign cfg_ready = (r_state == c_st_idle);
    assign w_apply   = (r_state == c_st_apply);
    // A 3-bit index can address up to 8 channels; anything past CHANNELS is
    // reported and otherwise dropped.
    assign w_bad_ch  = ({1'b0, r_cfg_ch} >= c_channels);
    // Decoded straight from registered state, so it is high for the whole
    // APPLY cycle and falls immediately when reset forces IDLE.
    assign cfg_err   = w_apply && w_bad_ch;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [ACC_W-1:0] r_acc;
        logic [ACC_W-1:0] r_inc;
        logic [ACC_W:0]   w_sum;
        logic             r_ce;
        logic             r_lock;
        logic [7:0]       r_cnt;
        logic             w_hit;

        // Extra top bit of the sum is the carry that produces a ce pulse.
        assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};
        assign w_hit = w_apply && !w_bad_ch && (r_cfg_ch == 3'(c));

        // Phase accumulator and ce pulse; a reconfiguration restarts the
        // phase from zero and swallows any carry on the apply edge.
        always_ff @(posedge clkin or negedge reset_n) begin
            if (!reset_n) begin
                r_acc <= '0;
                r_inc <= c_init_inc;
                r_ce  <= 1'b0;
            end else if (w_hit) begin
                r_acc <= '0;
                r_inc <= r_cfg_inc;
                r_ce  <= 1'b0;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
                r_ce  <= w_sum[ACC_W];
            end
        end

        // Lock tracking: count visible ce pulses up to LOCK_PULSES and raise
        // lock on the edge that consumes the final one. A zero increment
        // can never lock.
        always_ff @(posedge clkin or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt  <= '0;
                r_lock <= 1'b0;
            end else if (w_hit) begin
                r_cnt  <= '0;
                r_lock <= 1'b0;
            end else if (r_ce && (r_cnt != c_lock_pulses)) begin
                r_cnt <= r_cnt + 8'd1;
                if ((r_cnt == c_lock_pulses - 8'd1) && (r_inc != '0)) begin
                    r_lock <= 1'b1;
                end
            end
        end

        assign ce_out[c] = r_ce;
        assign lock[c]   = r_lock;
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_enable_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_clk_enable_gen
// Description : Self-checking bench for clk_enable_gen (2 ch, 8-bit acc,
//               INIT_INC 0x40, 4 lock pulses). Stimulus pushes the expected
//               ce pulse cycles per channel into queues. A negedge monitor
//               pops one entry per observed pulse and compares the cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_enable_gen;

    logic       clkin;
    logic       reset_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_ch;
    logic [7:0] cfg_inc;
    logic       cfg_err;
    logic [1:0] ce_out;
    logic [1:0] lock;

    int checks = 0;
    int errors = 0;
    int cyc;
    int q0[$];
    int q1[$];
    logic [7:0] burst_inc [6];
    logic       bad;

    clk_enable_gen #(
        .CHANNELS    (2),
        .ACC_W       (8),
        .INIT_INC    (32'h0000_0040),
        .LOCK_PULSES (4)
    ) dut (
        .clkin     (clkin),
        .reset_n   (reset_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_err   (cfg_err),
        .ce_out    (ce_out),
        .lock      (lock)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    // Cycle index: number of rising edges since reset release.
    always @(posedge clkin or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clkin);
    endtask

    // Monitor: every ce pulse must match the next expected cycle of its channel.
    always @(negedge clkin) begin
        if (reset_n) begin
            if (ce_out[0]) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ce0_unexpected at cycle %0d: got pulse expected none", cyc);
                end else check("ce0_time", 32'(cyc), 32'(q0.pop_front()));
            end
            if (ce_out[1]) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ce1_unexpected at cycle %0d: got pulse expected none", cyc);
                end else check("ce1_time", 32'(cyc), 32'(q1.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        burst_inc = '{8'h80, 8'h01, 8'hFF, 8'h02, 8'h20, 8'h03};
        cfg_valid = 1'b0;
        cfg_ch    = 3'd0;
        cfg_inc   = 8'h00;
        reset_n   = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check("rst_ce",    ce_out,    0);
        check("rst_lock",  lock,      0);
        check("rst_err",   cfg_err,   0);
        check("rst_ready", cfg_ready, 1);

        // Both channels run at 0x40 (period 4). Ch0 runs until reconfigured
        // at cycle 1102. Ch1 is reconfigured to inc 1 at cycle 32, giving
        // period 256 from there.
        for (int t = 4; t <= 1100; t += 4) q0.push_back(t);
        for (int t = 4; t <= 28; t += 4)   q1.push_back(t);
        for (int t = 288; t <= 2336; t += 256) q1.push_back(t);

        repeat (3) @(negedge clkin);
        reset_n = 1'b1;

        wait_cyc(16);
        check("lock_before_4th", lock, 2'b00);
        @(negedge clkin);
        check("lock_after_4th", lock, 2'b11);

        // Reconfigure ch1 with inc 1: accept edge 31, apply edge 32.
        wait_cyc(30);
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_inc = 8'h01;
        @(negedge clkin);
        check("ch1_apply_ready", cfg_ready, 0);
        check("ch1_lock_pre",    lock,      2'b11);
        cfg_valid = 1'b0;
        @(negedge clkin);
        check("ch1_lock_drop",   lock,      2'b01);
        wait_cyc(1056);
        check("ch1_lock_1056",   lock,      2'b01);
        @(negedge clkin);
        check("ch1_lock_1057",   lock,      2'b11);

        // Ch0 to inc 0: apply edge 1102, then silence.
        wait_cyc(1100);
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_inc = 8'h00;
        @(negedge clkin);
        cfg_valid = 1'b0;
        @(negedge clkin);
        check("ch0_lock_drop", lock, 2'b10);
        bad = 1'b0;
        while (cyc < 2200) begin
            @(negedge clkin);
            if (lock[0]) bad = 1'b1;
        end
        check("ch0_lock_low_inc0", bad, 0);

        // Out-of-range channel: one-cycle cfg_err, no channel change.
        check("err_idle", cfg_err, 0);
        cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_inc = 8'h10;
        @(negedge clkin);
        check("err_pulse",       cfg_err,   1);
        check("err_apply_ready", cfg_ready, 0);
        cfg_valid = 1'b0;
        @(negedge clkin);
        check("err_gone", cfg_err, 0);
        check("err_lock", lock,    2'b10);

        // Six-cycle held request: accepts 0x80, 0xFF, 0x20; final apply edge
        // 2306 leaves ch0 at period 8 from cycle 2314.
        for (int t = 2314; t <= 2410; t += 8) q0.push_back(t);
        wait_cyc(2300);
        for (int i = 0; i < 6; i++) begin
            check("burst_ready", cfg_ready, (i % 2 == 0) ? 32'd1 : 32'd0);
            cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_inc = burst_inc[i];
            @(negedge clkin);
        end
        cfg_valid = 1'b0;
        check("burst_ready_end", cfg_ready, 1);
        wait_cyc(2338);
        check("burst_lock_2338", lock, 2'b10);
        @(negedge clkin);
        check("burst_lock_2339", lock, 2'b11);

        // Reset in the middle of APPLY for a ch1 request.
        wait_cyc(2409);
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_inc = 8'h80;
        @(negedge clkin);
        check("mid_ready", cfg_ready, 0);
        check("mid_ce",    ce_out,    2'b01);
        check("mid_lock",  lock,      2'b11);
        cfg_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("async_ce",    ce_out,    0);
        check("async_lock",  lock,      0);
        check("async_err",   cfg_err,   0);
        check("async_ready", cfg_ready, 1);
        check("q0_drained",  q0.size(), 0);
        check("q1_drained",  q1.size(), 0);

        // After release both channels must be back at INIT_INC (period 4).
        for (int t = 4; t <= 20; t += 4) begin
            q0.push_back(t);
            q1.push_back(t);
        end
        repeat (3) @(negedge clkin);
        reset_n = 1'b1;
        wait_cyc(16);
        check("post_lock_16", lock, 2'b00);
        @(negedge clkin);
        check("post_lock_17", lock, 2'b11);
        wait_cyc(22);
        check("q0_final", q0.size(), 0);
        check("q1_final", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_enable_gen.md
CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 2, number of independent clock-enable channels (1..8).
REQ-002 The block SHALL have parameter ACC_W, default 16, phase-accumulator and increment width (4..32).
REQ-003 The block SHALL have parameter INIT_INC, default 16'h4000, increment loaded into every channel at reset.
REQ-004 The block SHALL have parameter LOCK_PULSES, default 4, the number of ce pulses after (re)configuration before lock asserts (1..255).
REQ-005 The block SHALL have port clkin, input, 1, the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port cfg_valid, input, 1, configuration request.
REQ-008 The block SHALL have port cfg_ready, output, 1, configuration accept.
REQ-009 The block SHALL have port cfg_ch, input, 3, target channel index.
REQ-010 The block SHALL have port cfg_inc, input, ACC_W, new increment.
REQ-011 The block SHALL have port cfg_err, output, 1, one-cycle pulse on an accepted request with cfg_ch >= CHANNELS.
REQ-012 The block SHALL have port ce_out, output, CHANNELS, one-cycle clock-enable pulses, bit c per channel.
REQ-013 The block SHALL have port lock, output, CHANNELS, per-channel output-stable flag.

Function
REQ-014 Each channel c SHALL add inc[c] to acc[c] every cycle, modulo 2^ACC_W, so that f_ce = f_clkin * inc / 2^ACC_W.
REQ-015 ce_out[c] SHALL be registered and high for exactly the one cycle following an edge whose addition carried out of bit ACC_W-1.
REQ-016 When inc[c] = 0, ce_out[c] SHALL stay low permanently.
REQ-017 The configuration FSM SHALL have two states:
  - IDLE: cfg_ready = 1.
  - APPLY: cfg_ready = 0.
REQ-018 On cfg_valid && cfg_ready, the FSM SHALL capture cfg_ch and cfg_inc and move IDLE->APPLY; APPLY SHALL always return to IDLE after one cycle, giving a maximum of one accepted request per 2 cycles.
REQ-019 In APPLY with a valid channel, the block SHALL, on the same edge:
  - write inc[ch];
  - clear acc[ch], lock[ch] and the pulse counter of ch;
  - suppress ce_out[ch] for that edge.
  Other channels SHALL be unaffected.
REQ-020 In APPLY with cfg_ch >= CHANNELS, the block SHALL change no channel state and SHALL pulse cfg_err high for that one cycle.
REQ-021 cfg_valid while cfg_ready = 0 SHALL be ignored; the requester SHALL hold it until accepted.
REQ-022 Each channel SHALL count ce pulses with a counter saturating at LOCK_PULSES.
REQ-023 lock[c] SHALL be registered and SHALL rise on the cycle after ce_out[c] shows the LOCK_PULSES-th pulse; it SHALL stay high until reset or reconfiguration of c.
REQ-024 lock[c] SHALL never assert while inc[c] = 0.
REQ-025 Reconfiguring a channel with its current increment SHALL still restart it (REQ-019).

Reset
REQ-026 While reset_n = 0, the block SHALL immediately (asynchronously) drive:
  - acc = 0, inc = INIT_INC[ACC_W-1:0] for all channels;
  - counters = 0;
  - ce_out = 0, lock = 0, cfg_err = 0;
  - FSM = IDLE, cfg_ready = 1.
REQ-027 Reset asserted during APPLY SHALL discard the pending request.
REQ-028 The first accumulation SHALL occur on the first rising clkin edge after reset_n deasserts.

Verification (CHANNELS=2, ACC_W=8, INIT_INC=8'h40, LOCK_PULSES=4)
REQ-029 After reset release, the bench SHALL check:
  - ce_out[0] and ce_out[1] pulse once every 4 cycles, first pulse after the 4th edge;
  - lock = 2'b11 one cycle after the 4th pulse (16 cycles).
REQ-030 The bench SHALL configure ch1 with inc=8'h01 and check:
  - lock[1] drops on the apply edge;
  - ce_out[1] then pulses every 256 cycles;
  - lock[1] rises after 1024 cycles;
  - ch0 cadence is unchanged throughout.
REQ-031 The bench SHALL configure ch0 with inc=0 and check ce_out[0] and lock[0] stay low for at least 1000 cycles.
REQ-032 The bench SHALL send cfg_ch=5 and check cfg_err pulses for exactly 1 cycle with no change to either channel.
REQ-033 The bench SHALL hold cfg_valid high for 6 cycles with changing cfg_inc and check:
  - exactly 3 accepts;
  - cfg_ready pattern 1,0,1,0,1,0.
REQ-034 The bench SHALL assert reset_n low mid-APPLY and check all outputs take their REQ-026 values without waiting for a clock edge, and that the request is not applied.
